// File: rtl/rgbw_spi_pkg.sv
// Shared frame layout and FSM encoding for the RGBW lamp SPI link.
package rgbw_spi_pkg;

  localparam int unsigned FRAME_BYTES = 7;
  localparam int unsigned FRAME_BITS  = FRAME_BYTES * 8;

  // Byte positions on the wire; the lamp's data dispenser uses the same map.
  localparam logic [2:0] IDX_LINT      = 3'd0;
  localparam logic [2:0] IDX_RED       = 3'd1;
  localparam logic [2:0] IDX_GREEN     = 3'd2;
  localparam logic [2:0] IDX_BLUE      = 3'd3;
  localparam logic [2:0] IDX_WHITE     = 3'd4;
  localparam logic [2:0] IDX_COLOR_IDX = 3'd5;
  localparam logic [2:0] IDX_MODE      = 3'd6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    HOLD  = 3'd4
  } state_e;

endpackage

// File: rtl/spi_phase_counter.sv
// Loadable down-counter; o_tc flags the last cycle of a timed phase.
module spi_phase_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/rgbw_frame_spi_master.sv
// SPI mode-0 master sending one 7-byte RGBW frame, MSB first, per accepted start.
module rgbw_frame_spi_master
  import rgbw_spi_pkg::*;
#(
  parameter int unsigned SCK_DIV  = 4,
  parameter int unsigned CS_SETUP = 4,
  parameter int unsigned CS_HOLD  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] lint,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
  input  logic [7:0] white,
  input  logic [7:0] color_idx,
  input  logic [7:0] mode,
  output logic       busy,
  output logic       done,
  output logic [2:0] byte_idx,
  output logic       sck,
  output logic       cs,
  output logic       mosi
);

  // Phases last N cycles by loading N-1 on entry and leaving on terminal count.
  localparam logic [7:0] L_SETUP = 8'(CS_SETUP - 1);
  localparam logic [7:0] L_DIV   = 8'(SCK_DIV - 1);
  localparam logic [7:0] L_HOLD  = 8'(CS_HOLD - 1);

  state_e                r_state;
  logic [FRAME_BITS-1:0] r_shift;
  logic [5:0]            r_bit_cnt;
  logic                  r_sck;
  logic                  r_cs;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_load;
  logic [7:0]            w_load_val;
  logic                  w_tc;
  logic                  w_last_bit;

  assign w_last_bit = (r_bit_cnt == 6'(FRAME_BITS - 1));

  spi_phase_counter #(
    .WIDTH(8)
  ) u_phase (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tc       (w_tc)
  );

  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load     = 1'b1;
          w_load_val = L_SETUP;
        end
      end
      SETUP, LOW: begin
        if (w_tc) begin
          w_load     = 1'b1;
          w_load_val = L_DIV;
        end
      end
      HIGH: begin
        if (w_tc) begin
          w_load     = 1'b1;
          w_load_val = w_last_bit ? L_HOLD : L_DIV;
        end
      end
      default: ;
    endcase
  end

  // mosi is the shift register MSB; clearing the register holds mosi at 0 in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_sck     <= 1'b0;
      r_cs      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_shift   <= {lint, red, green, blue, white, color_idx, mode};
            r_bit_cnt <= '0;
            r_cs      <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= SETUP;
          end
        end
        SETUP: begin
          if (w_tc) r_state <= LOW;
        end
        LOW: begin
          if (w_tc) begin
            r_sck   <= 1'b1;
            r_state <= HIGH;
          end
        end
        HIGH: begin
          if (w_tc) begin
            r_sck <= 1'b0;
            if (!w_last_bit) begin
              r_shift   <= {r_shift[FRAME_BITS-2:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_state   <= LOW;
            end else begin
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (w_tc) begin
            r_cs      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign sck      = r_sck;
  assign cs       = r_cs;
  assign mosi     = r_shift[FRAME_BITS-1];
  assign busy     = r_busy;
  assign done     = r_done;
  assign byte_idx = r_bit_cnt[5:3];

endmodule

// File: tb/tb_rgbw_frame_spi_master.sv
// Bench for rgbw_frame_spi_master: default instance plus a fast-timing instance.
module tb_rgbw_frame_spi_master;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] start;
  logic [7:0] lint, red, green, blue, white, color_idx, mode;
  logic [1:0] busy, done, sck, cs, mosi;
  logic [2:0] bidx [2];

  rgbw_frame_spi_master dut0 (
    .clk(clk), .reset(reset), .start(start[0]),
    .lint(lint), .red(red), .green(green), .blue(blue), .white(white),
    .color_idx(color_idx), .mode(mode),
    .busy(busy[0]), .done(done[0]), .byte_idx(bidx[0]),
    .sck(sck[0]), .cs(cs[0]), .mosi(mosi[0])
  );

  rgbw_frame_spi_master #(.SCK_DIV(2), .CS_SETUP(1), .CS_HOLD(1)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]),
    .lint(lint), .red(red), .green(green), .blue(blue), .white(white),
    .color_idx(color_idx), .mode(mode),
    .busy(busy[1]), .done(done[1]), .byte_idx(bidx[1]),
    .sck(sck[1]), .cs(cs[1]), .mosi(mosi[1])
  );

  int unsigned errors = 0;
  int unsigned checks = 0;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int unsigned p_setup(input int i); return (i == 0) ? 4 : 1; endfunction
  function automatic int unsigned p_div(input int i);   return (i == 0) ? 4 : 2; endfunction
  function automatic int unsigned p_hold(input int i);  return (i == 0) ? 4 : 1; endfunction
  function automatic int unsigned flen(input int i);
    return p_setup(i) + 112 * p_div(i) + p_hold(i);
  endfunction

  // Reference model: frame position t counted from the first cs-low cycle.
  bit          m_active [2];
  bit          m_done   [2];
  int unsigned m_t      [2];
  logic [55:0] m_frame  [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_active[i] = 1'b0;
        m_done[i]   = 1'b0;
      end else if (m_active[i]) begin
        m_t[i]++;
        if (m_t[i] == flen(i)) begin
          m_active[i] = 1'b0;
          m_done[i]   = 1'b1;
        end
      end else begin
        m_done[i] = 1'b0;
        if (start[i]) begin
          m_active[i] = 1'b1;
          m_t[i]      = 0;
          m_frame[i]  = {lint, red, green, blue, white, color_idx, mode};
        end
      end
    end
  end

  // Expected {cs, sck, mosi, busy, done, byte_idx}.
  function automatic logic [7:0] exp_out(input int i);
    int unsigned s, d, t, u, k;
    logic        sck_e;
    if (!m_active[i]) return {1'b1, 1'b0, 1'b0, 1'b0, m_done[i], 3'd0};
    s = p_setup(i);
    d = p_div(i);
    t = m_t[i];
    k = 0;
    sck_e = 1'b0;
    if (t >= s) begin
      u = t - s;
      if (u < 112 * d) begin
        sck_e = ((u / d) % 2) == 1;
        k     = u / (2 * d);
      end else begin
        k = 55;
      end
    end
    return {1'b0, sck_e, m_frame[i][55-k], 1'b1, 1'b0, 3'(k / 8)};
  endfunction

  // SPI slave / waveform monitor state.
  int unsigned low_cyc [2], rises [2], busy_cyc [2], first_rise [2];
  int unsigned last_len [2], last_rises [2], last_busy [2], last_first [2];
  int unsigned nframes [2], hi_chg [2], done_cnt [2], gap [2], min_gap [2];
  logic [55:0] sr [2], last_bits [2];
  logic        p_sck [2], p_cs [2], p_mosi [2];
  logic [7:0]  bytes_q [$];
  int unsigned len_q [$];

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic [7:0] e, a;
        e = exp_out(i);
        a = {cs[i], sck[i], mosi[i], busy[i], done[i], bidx[i]};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL model_cmp inst%0d t=%0d: got %b expected %b (cs,sck,mosi,busy,done,idx)",
                   i, m_t[i], a, e);
        end
        if (done[i]) done_cnt[i]++;
        if (!cs[i]) begin
          if (p_cs[i]) begin
            if (nframes[i] > 0 && gap[i] < min_gap[i]) min_gap[i] = gap[i];
            low_cyc[i] = 0; rises[i] = 0; busy_cyc[i] = 0; sr[i] = '0;
          end
          low_cyc[i]++;
          if (busy[i]) busy_cyc[i]++;
          if (sck[i] && !p_sck[i]) begin
            rises[i]++;
            sr[i] = {sr[i][54:0], mosi[i]};
            if (rises[i] == 1) first_rise[i] = low_cyc[i] - 1;
            if (i == 0 && (rises[i] % 8) == 0) bytes_q.push_back(sr[i][7:0]);
          end
          if (sck[i] && p_sck[i] && mosi[i] != p_mosi[i]) hi_chg[i]++;
        end else begin
          if (!p_cs[i]) begin
            last_len[i] = low_cyc[i]; last_bits[i] = sr[i]; last_rises[i] = rises[i];
            last_busy[i] = busy_cyc[i]; last_first[i] = first_rise[i];
            nframes[i]++;
            if (i == 0) len_q.push_back(low_cyc[i]);
            gap[i] = 0;
          end
          gap[i]++;
        end
        p_sck[i] = sck[i]; p_cs[i] = cs[i]; p_mosi[i] = mosi[i];
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_bytes(input logic [55:0] v);
    {lint, red, green, blue, white, color_idx, mode} = v;
  endtask

  function automatic logic [55:0] rnd56();
    return 56'({$urandom(), $urandom()});
  endfunction

  task automatic send(input int i, input logic [55:0] v);
    set_bytes(v);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
  endtask

  task automatic wait_frame(input int i, input int unsigned n0);
    int unsigned k = 0;
    while (nframes[i] <= n0 && k < 5000) begin
      tick();
      k++;
    end
    if (nframes[i] <= n0) check("frame_timeout", 64'd0, 64'd1);
  endtask

  logic [7:0]  eb [7];
  logic [55:0] v;
  int unsigned n;

  initial begin
    eb = '{8'hA5, 8'h01, 8'h80, 8'hFF, 8'h00, 8'h3C, 8'h81};
    for (int i = 0; i < 2; i++) begin
      low_cyc[i] = 0; rises[i] = 0; busy_cyc[i] = 0; first_rise[i] = 0; nframes[i] = 0;
      hi_chg[i] = 0; done_cnt[i] = 0; gap[i] = 0; min_gap[i] = 32'hFFFF_FFFF;
      sr[i] = '0; p_sck[i] = 1'b0; p_cs[i] = 1'b1; p_mosi[i] = 1'b0;
    end
    reset = 1'b1;
    start = '0;
    set_bytes('0);
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_cs",   64'(cs[0]),   64'd1);
    check("rst_sck",  64'(sck[0]),  64'd0);
    check("rst_mosi", 64'(mosi[0]), 64'd0);
    check("rst_busy", 64'(busy[0]), 64'd0);
    check("rst_done", 64'(done[0]), 64'd0);
    check("rst_idx",  64'(bidx[0]), 64'd0);
    reset = 1'b0;
    tick();

    // Known frame content and default timing.
    bytes_q.delete();
    done_cnt[0] = 0;
    n = nframes[0];
    send(0, 56'hA5_01_80_FF_00_3C_81);
    set_bytes(rnd56());
    wait_frame(0, n);
    tick();
    check("bits",       64'(last_bits[0]),  64'h00A5_0180_FF00_3C81);
    check("cs_low_len", 64'(last_len[0]),   64'd456);
    check("sck_rises",  64'(last_rises[0]), 64'd56);
    check("first_rise", 64'(last_first[0]), 64'd8);
    check("busy_len",   64'(last_busy[0]),  64'd456);
    check("done_pulse", 64'(done_cnt[0]),   64'd1);
    check("byte_count", 64'(bytes_q.size()), 64'd7);
    for (int j = 0; j < bytes_q.size() && j < 7; j++) check("slave_byte", 64'(bytes_q[j]), 64'(eb[j]));

    // Fast timing instance.
    hi_chg[1] = 0;
    for (int r = 0; r < 3; r++) begin
      v = rnd56();
      n = nframes[1];
      send(1, v);
      set_bytes(rnd56());
      wait_frame(1, n);
      check("fast_len",   64'(last_len[1]),   64'd226);
      check("fast_bits",  64'(last_bits[1]),  64'(v));
      check("fast_rises", 64'(last_rises[1]), 64'd56);
      check("fast_first", 64'(last_first[1]), 64'd3);
    end
    check("fast_mosi_hi_stable", 64'(hi_chg[1]), 64'd0);

    // start held high for 600 cycles.
    min_gap[0] = 32'hFFFF_FFFF;
    len_q.delete();
    n = nframes[0];
    start[0] = 1'b1;
    repeat (600) begin
      set_bytes(rnd56());
      tick();
    end
    start[0] = 1'b0;
    wait_frame(0, n + 1);
    repeat (50) tick();
    check("held_frames", 64'(nframes[0] - n), 64'd2);
    check("held_nlen",   64'(len_q.size()),   64'd2);
    for (int j = 0; j < len_q.size(); j++) check("held_len", 64'(len_q[j]), 64'd456);
    check("held_gap",    64'(min_gap[0]),     64'd1);
    check("held_bits2",  64'(last_bits[0]),   64'(m_frame[0]));

    // reset during byte 3, bit 4.
    v = rnd56();
    send(0, v);
    begin
      int unsigned k = 0;
      while (!(m_active[0] && m_t[0] >= 4 + 28 * 8 + 6) && k < 2000) begin
        tick();
        k++;
      end
      if (k >= 2000) check("reset_wait_timeout", 64'd0, 64'd1);
    end
    reset = 1'b1;
    tick();
    check("abort_cs",   64'(cs[0]),   64'd1);
    check("abort_sck",  64'(sck[0]),  64'd0);
    check("abort_mosi", 64'(mosi[0]), 64'd0);
    check("abort_busy", 64'(busy[0]), 64'd0);
    check("abort_done", 64'(done[0]), 64'd0);
    reset = 1'b0;
    tick();
    v = rnd56();
    n = nframes[0];
    send(0, v);
    set_bytes(rnd56());
    wait_frame(0, n);
    check("post_reset_bits",  64'(last_bits[0]),  64'(v));
    check("post_reset_len",   64'(last_len[0]),   64'd456);
    check("post_reset_rises", 64'(last_rises[0]), 64'd56);

    // start pulses and byte changes while busy.
    v = rnd56();
    n = nframes[0];
    send(0, v);
    repeat (400) begin
      start[0] = 1'($urandom_range(0, 1));
      set_bytes(rnd56());
      tick();
    end
    start[0] = 1'b0;
    wait_frame(0, n);
    repeat (5) tick();
    check("busy_start_bits",   64'(last_bits[0]),  64'(v));
    check("busy_start_len",    64'(last_len[0]),   64'd456);
    check("busy_start_frames", 64'(nframes[0] - n), 64'd1);
    check("mosi_hi_stable",    64'(hi_chg[0]),     64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
